// File: rtl/br_recov_ctl_pkg.sv
// Shared branch-recovery types: ROB id, physical/ROM address widths, the
// mispredict packet, the recovery FSM state enum and the ROB age compare.
package br_recov_ctl_pkg;

  localparam int unsigned ROB_ID_W   = 6;
  localparam int unsigned PADDR_W    = 32;
  localparam int unsigned ROM_ADDR_W = 12;

  typedef logic [ROB_ID_W-1:0]   t_rob_id;
  typedef logic [PADDR_W-1:0]    t_paddr;
  typedef logic [ROM_ADDR_W-1:0] t_rom_addr;

  typedef struct packed {
    logic    valid;
    t_paddr  target_addr;
    t_rob_id robid;
    logic    ucbr;
  } t_br_mispred_pkt;

  typedef enum logic [1:0] {
    BR_RECOV_IDLE,
    BR_RECOV_FLUSH,
    BR_RECOV_REDIRECT
  } t_br_recov_state;

  // True when a is strictly older than b; ages are distances from the ROB
  // head taken modulo the robid width, so wrap-around is handled naturally.
  function automatic logic rob_age_lt(t_rob_id a, t_rob_id b, t_rob_id head);
    t_rob_id age_a;
    t_rob_id age_b;
    age_a = a - head;
    age_b = b - head;
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/br_recov_ctl_if.sv
// Branch-recovery bus: mispredict ports and ROB head in, flush pulse and
// front-end / microcode-sequencer redirect handshakes out.
// master: the recovery controller side; slave: branch units, ROB and consumers.
interface br_recov_ctl_if #(
  parameter int unsigned NUM_BR = 2
);
  import br_recov_ctl_pkg::*;

  t_br_mispred_pkt br_mispred_ex0 [NUM_BR];
  t_rob_id         rob_head_robid;
  logic            flush_valid;
  t_rob_id         flush_robid;
  logic            fe_redirect_valid;
  t_paddr          fe_redirect_addr;
  logic            fe_redirect_rdy;
  logic            us_redirect_valid;
  t_rom_addr       us_redirect_addr;
  logic            us_redirect_rdy;

  modport master (
    input  br_mispred_ex0, rob_head_robid, fe_redirect_rdy, us_redirect_rdy,
    output flush_valid, flush_robid, fe_redirect_valid, fe_redirect_addr,
           us_redirect_valid, us_redirect_addr
  );

  modport slave (
    output br_mispred_ex0, rob_head_robid, fe_redirect_rdy, us_redirect_rdy,
    input  flush_valid, flush_robid, fe_redirect_valid, fe_redirect_addr,
           us_redirect_valid, us_redirect_addr
  );

endinterface

// File: rtl/br_recov_ctl_oldest_sel.sv
// br_oldest_sel: combinational NUM_BR-way oldest-mispredict select.
// Ports: pkts (mispredict packets), head (ROB head robid) in;
//        sel_idx (winning port), sel_pkt (winning packet), sel_valid (any valid) out.
// Ties on age go to the lower port index.
module br_oldest_sel
  import br_recov_ctl_pkg::*;
#(
  parameter int unsigned NUM_BR = 2,
  parameter int unsigned IDX_W  = (NUM_BR > 1) ? $clog2(NUM_BR) : 1
) (
  input  t_br_mispred_pkt  pkts [NUM_BR],
  input  t_rob_id          head,
  output logic [IDX_W-1:0] sel_idx,
  output t_br_mispred_pkt  sel_pkt,
  output logic             sel_valid
);

  always_comb begin
    sel_idx   = '0;
    sel_pkt   = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_BR; i++) begin
      // strict compare keeps the earlier (lower-index) winner on a tie
      if (pkts[i].valid && (!sel_valid || rob_age_lt(pkts[i].robid, sel_pkt.robid, head))) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_pkt   = pkts[i];
      end
    end
  end

endmodule

// File: rtl/br_recov_ctl.sv
// br_recov_ctl: branch-recovery controller. Picks the oldest same-cycle
// mispredict, pulses a machine flush, then redirects fetch or the microcode
// sequencer. Older mispredicts pre-empt an in-flight recovery; younger ones drop.
// Ports: clk, reset (sync, active high); bus (br_recov_ctl_if.master);
//        busy, mispred_cnt, ucbr_cnt (saturating capture counters).
module br_recov_ctl
  import br_recov_ctl_pkg::*;
#(
  parameter int unsigned NUM_BR = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  br_recov_ctl_if.master   bus,
  output logic             busy,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ucbr_cnt
);

  localparam int unsigned IDX_W = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;

  t_br_recov_state  state, state_next;
  t_rob_id          cap_robid;
  t_paddr           cap_target;
  logic             cap_ucbr;

  logic [IDX_W-1:0] sel_idx;
  t_br_mispred_pkt  sel_pkt;
  logic             sel_valid;
  logic             sel_older;
  logic             load;
  logic             handshake;
  logic             unused_sel;

  br_oldest_sel #(.NUM_BR(NUM_BR)) u_sel (
    .pkts      (bus.br_mispred_ex0),
    .head      (bus.rob_head_robid),
    .sel_idx   (sel_idx),
    .sel_pkt   (sel_pkt),
    .sel_valid (sel_valid)
  );

  assign unused_sel = ^{sel_pkt.valid, sel_idx};
  assign sel_older  = sel_valid && rob_age_lt(sel_pkt.robid, cap_robid, bus.rob_head_robid);
  assign handshake  = (state == BR_RECOV_REDIRECT) &&
                      (cap_ucbr ? bus.us_redirect_rdy : bus.fe_redirect_rdy);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      BR_RECOV_IDLE: begin
        if (sel_valid) begin
          load       = 1'b1;
          state_next = BR_RECOV_FLUSH;
        end
      end
      BR_RECOV_FLUSH: begin
        load       = sel_older;
        state_next = sel_older ? BR_RECOV_FLUSH : BR_RECOV_REDIRECT;
      end
      BR_RECOV_REDIRECT: begin
        // an older mispredict wins over a same-cycle handshake
        if (sel_older) begin
          load       = 1'b1;
          state_next = BR_RECOV_FLUSH;
        end else if (handshake) begin
          state_next = BR_RECOV_IDLE;
        end
      end
      default: state_next = BR_RECOV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BR_RECOV_IDLE;
      cap_robid   <= '0;
      cap_target  <= '0;
      cap_ucbr    <= 1'b0;
      mispred_cnt <= '0;
      ucbr_cnt    <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        cap_robid  <= sel_pkt.robid;
        cap_target <= sel_pkt.target_addr;
        cap_ucbr   <= sel_pkt.ucbr;
        if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
        if (sel_pkt.ucbr && (ucbr_cnt != '1)) ucbr_cnt <= ucbr_cnt + CNT_W'(1);
      end
    end
  end

  assign busy                  = (state != BR_RECOV_IDLE);
  assign bus.flush_valid       = (state == BR_RECOV_FLUSH);
  assign bus.flush_robid       = cap_robid;
  assign bus.fe_redirect_valid = (state == BR_RECOV_REDIRECT) && !cap_ucbr;
  assign bus.us_redirect_valid = (state == BR_RECOV_REDIRECT) && cap_ucbr;
  assign bus.fe_redirect_addr  = cap_target;
  assign bus.us_redirect_addr  = cap_target[ROM_ADDR_W-1:0];

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset && load)
      $display("UINFO br_recov_ctl: %s robid=%0d port=%0d tgt=%h ucbr=%0b",
               (state == BR_RECOV_IDLE) ? "capture" : "preempt",
               sel_pkt.robid, sel_idx, sel_pkt.target_addr, sel_pkt.ucbr);
    if (!reset && handshake && !sel_older)
      $display("UINFO br_recov_ctl: redirect handshake robid=%0d ucbr=%0b", cap_robid, cap_ucbr);
  end
`endif

`ifdef ASSERT
  // The captured entry's distance from the ROB head may only shrink while
  // it is held; growth means the head moved past it.
  t_rob_id last_age;
  logic    last_hold;
  always_ff @(posedge clk) begin
    if (reset) begin
      last_age  <= '0;
      last_hold <= 1'b0;
    end else begin
      if (busy && last_hold)
        assert (t_rob_id'(cap_robid - bus.rob_head_robid) <= last_age)
          else $error("br_recov_ctl: rob head passed captured robid %0d", cap_robid);
      last_age  <= cap_robid - bus.rob_head_robid;
      last_hold <= busy && !load && (state_next != BR_RECOV_IDLE);
    end
  end
`endif

endmodule
